// File: rtl/rv_soc_apb_arb_pkg.sv
// Shared types and helpers for the APB peripheral-bus arbiter.
package rv_soc_apb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_arb_state_e;

  // Index width that stays legal (>=1) for single-entry ranges.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rv_soc_rr_arbiter.sv
// Round-robin request picker: searches from ptr upward with wrap-around.
module rv_soc_rr_arbiter
  import rv_soc_apb_arb_pkg::*;
#(
  parameter int unsigned REQUESTERS = 2,
  localparam int unsigned IDX_W = clog2_min1(REQUESTERS)
) (
  input  logic [REQUESTERS-1:0] req,
  input  logic [IDX_W-1:0]      ptr,
  input  logic                  en,
  output logic [REQUESTERS-1:0] grant,
  output logic [IDX_W-1:0]      idx
);

  int unsigned      cand;
  logic [IDX_W-1:0] sel;
  logic             found;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    cand  = 0;
    sel   = '0;
    for (int unsigned k = 0; k < REQUESTERS; k++) begin
      cand = k + 32'(ptr);
      if (cand >= REQUESTERS) cand = cand - REQUESTERS;
      sel = IDX_W'(cand);
      if (en && !found && req[sel]) begin
        found      = 1'b1;
        grant[sel] = 1'b1;
        idx        = sel;
      end
    end
  end

endmodule

// File: rtl/rv_soc_apb_8b_arbiter.sv
// Serialises APB transfers from several masters onto one registered APB port,
// with round-robin arbitration and a PREADY watchdog.
module rv_soc_apb_8b_arbiter
  import rv_soc_apb_arb_pkg::*;
#(
  parameter int unsigned MASTERS    = 2,
  parameter int unsigned PADDR_SIZE = 16,
  parameter int unsigned PDATA_SIZE = 8,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic                      PCLK,
  input  logic                      PRESET,
  input  logic [MASTERS-1:0]        mst_PSEL,
  input  logic [MASTERS-1:0]        mst_PENABLE,
  input  logic [MASTERS-1:0]        mst_PWRITE,
  input  logic [2:0]                mst_PPROT  [MASTERS],
  input  logic [PDATA_SIZE/8-1:0]   mst_PSTRB  [MASTERS],
  input  logic [PADDR_SIZE-1:0]     mst_PADDR  [MASTERS],
  input  logic [PDATA_SIZE-1:0]     mst_PWDATA [MASTERS],
  output logic [PDATA_SIZE-1:0]     mst_PRDATA [MASTERS],
  output logic [MASTERS-1:0]        mst_PREADY,
  output logic [MASTERS-1:0]        mst_PSLVERR,
  output logic                      PSEL,
  output logic                      PENABLE,
  output logic                      PWRITE,
  output logic [2:0]                PPROT,
  output logic [PDATA_SIZE/8-1:0]   PSTRB,
  output logic [PADDR_SIZE-1:0]     PADDR,
  output logic [PDATA_SIZE-1:0]     PWDATA,
  input  logic [PDATA_SIZE-1:0]     PRDATA,
  input  logic                      PREADY,
  input  logic                      PSLVERR,
  output logic [MASTERS-1:0]        grant_o,
  output logic                      timeout_o
);

  localparam int unsigned IDX_W = clog2_min1(MASTERS);
  localparam int unsigned WD_W  = clog2_min1(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT);

  apb_arb_state_e  state, state_next;
  logic [IDX_W-1:0] ptr, owner, win_idx;
  logic [MASTERS-1:0] win_grant;
  logic [WD_W-1:0] wd_cnt;
  logic [PDATA_SIZE-1:0] rdata_q;
  logic slverr_q;
  logic abort;
  logic take;

  rv_soc_rr_arbiter #(.REQUESTERS(MASTERS)) u_rr (
    .req   (mst_PSEL),
    .ptr   (ptr),
    .en    (state == IDLE),
    .grant (win_grant),
    .idx   (win_idx)
  );

  assign take = (state == IDLE) && (|mst_PSEL);

  always_comb begin
    state_next = state;
    abort      = 1'b0;
    case (state)
      IDLE:   if (|mst_PSEL) state_next = SETUP;
      SETUP:  state_next = ACCESS;
      ACCESS: begin
        if (PREADY) begin
          state_next = RESP;
        end else if (TIMEOUT != 0 && wd_cnt == WD_LIMIT) begin
          abort      = 1'b1;
          state_next = RESP;
        end
      end
      RESP:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      ptr       <= '0;
      owner     <= '0;
      grant_o   <= '0;
      PSEL      <= 1'b0;
      PENABLE   <= 1'b0;
      PWRITE    <= 1'b0;
      PPROT     <= '0;
      PSTRB     <= '0;
      PADDR     <= '0;
      PWDATA    <= '0;
      wd_cnt    <= '0;
      rdata_q   <= '0;
      slverr_q  <= 1'b0;
      timeout_o <= 1'b0;
    end else begin
      timeout_o <= abort;
      // Bus control follows the next state so it is flop-driven, not decoded.
      PSEL      <= (state_next == SETUP) || (state_next == ACCESS);
      PENABLE   <= (state_next == ACCESS);
      if (take) begin
        owner   <= win_idx;
        grant_o <= win_grant;
        PWRITE  <= mst_PWRITE[win_idx];
        PPROT   <= mst_PPROT[win_idx];
        PSTRB   <= mst_PSTRB[win_idx];
        PADDR   <= mst_PADDR[win_idx];
        PWDATA  <= mst_PWDATA[win_idx];
        ptr     <= (win_idx == IDX_W'(MASTERS - 1)) ? '0 : win_idx + 1'b1;
      end
      if (state == RESP) grant_o <= '0;
      if (state == SETUP) begin
        wd_cnt <= '0;
      end else if (state == ACCESS && wd_cnt != '1) begin
        wd_cnt <= wd_cnt + 1'b1;
      end
      if (state == ACCESS) begin
        if (PREADY) begin
          rdata_q  <= PRDATA;
          slverr_q <= PSLVERR;
        end else if (abort) begin
          rdata_q  <= '0;
          slverr_q <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    mst_PREADY  = '0;
    mst_PSLVERR = '0;
    for (int unsigned m = 0; m < MASTERS; m++) begin
      mst_PRDATA[m] = '0;
      if (state == RESP && owner == IDX_W'(m)) begin
        mst_PREADY[m]  = mst_PSEL[m] & mst_PENABLE[m];
        mst_PSLVERR[m] = slverr_q;
        mst_PRDATA[m]  = rdata_q;
      end
    end
  end

endmodule

// File: doc/rv_soc_apb_8b_arbiter.md
# rv_soc_apb_8b_arbiter

Round-robin arbiter sharing the single 8-bit APB peripheral bus (GPIO/UART/I2C/SPI/user slave cluster) between several APB masters, e.g. the AHB-to-APB bridge, a debug port and a DMA engine. Each upstream master issues a normal APB transfer. The block serialises these transfers onto one registered downstream APB master port and returns the response to the granted master. A programmable watchdog ends any transfer whose slave never asserts PREADY, and returns PSLVERR to the master.

## Interface
- MASTERS, 2: number of upstream APB masters (≥1).
- PADDR_SIZE, 16: APB address width.
- PDATA_SIZE, 8: APB data width.
- TIMEOUT, 255: maximum ACCESS-phase cycles before abort; 0 disables the watchdog.

Ports:
- PCLK  in  1  clock; one clock domain. Reset is synchronous and active-high.
- PRESET  in  1  synchronous active-high reset.
- mst_PSEL, mst_PENABLE, mst_PWRITE  in  1 [MASTERS]  upstream APB control.
- mst_PPROT  in  3 [MASTERS]; mst_PSTRB  in  PDATA_SIZE/8 [MASTERS].
- mst_PADDR  in  PADDR_SIZE [MASTERS]; mst_PWDATA  in  PDATA_SIZE [MASTERS].
- mst_PRDATA  out  PDATA_SIZE [MASTERS]; mst_PREADY, mst_PSLVERR  out  1 [MASTERS].
- PSEL, PENABLE, PWRITE  out  1  downstream APB control (registered).
- PPROT out 3; PSTRB out PDATA_SIZE/8; PADDR out PADDR_SIZE; PWDATA out PDATA_SIZE (registered).
- PRDATA  in  PDATA_SIZE; PREADY, PSLVERR  in  1  downstream response.
- grant_o  out  MASTERS  one-hot index of the current owner; zero in IDLE.
- timeout_o  out  1  one-cycle pulse when the watchdog aborts a transfer.

## Operation
- Request from master i: mst_PSEL[i]=1. A master must hold its request until it sees its own mst_PREADY.
- FSM states: IDLE → SETUP → ACCESS → RESP → IDLE.
- IDLE:
  - If any request is present, pick a winner by round-robin, starting the search at ptr. ptr resets to 0.
  - Register the winner's PADDR/PWRITE/PWDATA/PSTRB/PPROT and grant index. Set ptr = winner+1 mod MASTERS.
  - Go to SETUP.
- SETUP: PSEL=1, PENABLE=0. Go to ACCESS.
- ACCESS: PSEL=1, PENABLE=1.
  - On PREADY=1, register PRDATA/PSLVERR, then go to RESP.
  - Else, if TIMEOUT≠0 and the watchdog count equals TIMEOUT, register PRDATA=0 and PSLVERR=1, pulse timeout_o, then go to RESP.
  - Watchdog counter width is $clog2(TIMEOUT+1). It clears on entry to ACCESS and saturates.
- RESP: PSEL=PENABLE=0.
  - mst_PREADY[g] = mst_PSEL[g] & mst_PENABLE[g]. mst_PRDATA[g] and mst_PSLVERR[g] carry the registered values.
  - Next state is always IDLE.
- Non-granted masters, and all masters outside RESP: mst_PREADY=0, mst_PRDATA=0, mst_PSLVERR=0.
- A master that drops PSEL before RESP is a protocol violation. The downstream transfer still completes and the response is discarded.
- Downstream control is registered. Upstream changes after grant do not affect the transfer in flight.

## Timing
- Reset: state=IDLE, ptr=0, grant_o=0, PSEL=PENABLE=PWRITE=0, PADDR/PWDATA/PSTRB/PPROT=0, timeout_o=0, all mst_* outputs 0.
- PRESET asserted mid-transfer aborts immediately. No response is given to the master; it must restart after reset.
- Zero-wait transfer, with the request sampled in IDLE at cycle t:
  - t+1: SETUP.
  - t+2: ACCESS, PREADY=1.
  - t+3: RESP, mst_PREADY=1.
  - t+4: IDLE, where the next grant can be made.
  - Throughput is one transfer per 4 cycles; each slave wait state adds 1 cycle.
- A master with back-to-back transfers (PSEL held, PENABLE low after RESP) is seen as a new request in the following IDLE.
- Simultaneous requests: the lowest index at or after ptr wins. Each waiting master is served within MASTERS transfers.
- Abort at TIMEOUT=N: RESP is N+1 cycles after entering ACCESS.

## Structure
- Package rv_soc_apb_arb_pkg holds the FSM state enum typedef (IDLE, SETUP, ACCESS, RESP).
- Sub-module rv_soc_rr_arbiter (parameter REQUESTERS) is natural. Inputs are req vector, ptr and an enable; outputs are the one-hot grant and the encoded index. It is reusable by future AHB-side arbiters.
- The top level holds the FSM, capture registers, watchdog and response steering.

## Test plan
- Single master, write 0xA5 to 0x0010, PREADY tied 1: downstream SETUP at t+1, ACCESS t+2; mst_PREADY[0]=1 at t+3; PWDATA=0xA5 and PADDR=0x0010 stable through SETUP/ACCESS.
- Masters 0 and 1 requesting continuously with reads: grants alternate 0,1,0,1 with ptr advancing. Read data 0x3C and 0xC3 is returned only to the matching master.
- Slave inserts 3 wait states and returns PSLVERR=1: RESP at ACCESS-entry+4, mst_PSLVERR=1 to the owner only.
- TIMEOUT=4, PREADY held 0: timeout_o pulses once, downstream PSEL drops, owner gets mst_PREADY=1 with PSLVERR=1 and PRDATA=0x00. TIMEOUT=0 with PREADY held 0 for 1000 cycles: no abort.
- PRESET asserted during ACCESS: next cycle all outputs at reset values and ptr=0. A pending request is granted normally after PRESET deasserts.
- MASTERS=3, only master 2 requesting, then masters 0 and 2 simultaneously: master 2 served first, then master 0 (ptr wrap-around).
